// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, word-width helper
// and a field view of a default-sized FP word.
package fp_pkg;

   localparam int FP_EXP_W_DEF  = 8;
   localparam int FP_MANT_W_DEF = 24;

   // Mantissa width includes the hidden bit, which takes the sign's slot.
   function automatic int fp_width(input int exp_w, input int mant_w);
      return exp_w + mant_w;
   endfunction

   typedef struct packed {
      logic                     sign;
      logic [FP_EXP_W_DEF-1:0]  exponent;
      logic [FP_MANT_W_DEF-2:0] fraction;
   } fp_word_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible on data_o
// whenever empty_o is low.
module fp_sync_fifo
   import fp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   // Storage is not reset: only pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue/return wrapper for an external fixed-latency fp_addsub: registers the
// operands, tracks results in flight and buffers them under credit flow control.
module fp_addsub_issue
   import fp_pkg::*;
#(
   parameter int EXPONENT_WIDTH = FP_EXP_W_DEF,
   parameter int MANTISSA_WIDTH = FP_MANT_W_DEF,
   parameter int ADDSUB_LATENCY = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int TAG_WIDTH      = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   req_valid_i,
   output logic                                   req_ready_o,
   input  logic                                   req_addsub_i,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] req_a_i,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] req_b_i,
   input  logic [TAG_WIDTH-1:0]                   req_tag_i,
   output logic                                   addsub_o,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] data_a_o,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] data_b_o,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] result_i,
   output logic                                   rsp_valid_o,
   input  logic                                   rsp_ready_i,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] rsp_result_o,
   output logic [TAG_WIDTH-1:0]                   rsp_tag_o,
   output logic                                   busy_o
);

   localparam int W     = fp_width(EXPONENT_WIDTH, MANTISSA_WIDTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on the partner's valid.
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 issue_valid_q;
   logic [TAG_WIDTH-1:0] issue_tag_q;
   logic                 trk_valid_q [ADDSUB_LATENCY];
   logic [TAG_WIDTH-1:0] trk_tag_q   [ADDSUB_LATENCY];
   logic [CNT_W-1:0]     inflight_q;
   logic [CNT_W-1:0]     fifo_count;
   logic [CNT_W:0]       used_credits;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [TAG_WIDTH+W-1:0] fifo_rdata;

   assign accept = req_valid_i && req_ready_o;
   assign push   = trk_valid_q[ADDSUB_LATENCY-1];
   assign pop    = rsp_valid_o && rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addsub_o      <= 1'b0;
         data_a_o      <= '0;
         data_b_o      <= '0;
         issue_valid_q <= 1'b0;
         issue_tag_q   <= '0;
      end else begin
         issue_valid_q <= accept;
         if (accept) begin
            addsub_o    <= req_addsub_i;
            data_a_o    <= req_a_i;
            data_b_o    <= req_b_i;
            issue_tag_q <= req_tag_i;
         end
      end
   end

   // The operand register is the first latency step, so these stages mark
   // result_i valid exactly ADDSUB_LATENCY edges after the accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ADDSUB_LATENCY; i++) begin
            trk_valid_q[i] <= 1'b0;
         end
      end else begin
         trk_valid_q[0] <= issue_valid_q;
         for (int i = 1; i < ADDSUB_LATENCY; i++) begin
            trk_valid_q[i] <= trk_valid_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      trk_tag_q[0] <= issue_tag_q;
      for (int i = 1; i < ADDSUB_LATENCY; i++) begin
         trk_tag_q[i] <= trk_tag_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_q <= '0;
      end else begin
         case ({accept, push})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= inflight_q - CNT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Every accepted op holds a FIFO slot from issue until it is popped.
   assign used_credits = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign req_ready_o  = (used_credits < (CNT_W+1)'(FIFO_DEPTH));

   fp_sync_fifo #(
      .WIDTH (TAG_WIDTH + W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  ({trk_tag_q[ADDSUB_LATENCY-1], result_i}),
      .pop_i   (pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rsp_valid_o  = !fifo_empty;
   assign rsp_result_o = fifo_rdata[W-1:0];
   assign rsp_tag_o    = fifo_rdata[TAG_WIDTH+W-1:W];
   assign busy_o       = (inflight_q != '0) || (fifo_count != '0);

   no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Bench for fp_addsub_issue paired with a behavioural fixed-latency adder;
// a transaction-level credit/order model predicts every output each cycle.
module tb_fp_addsub_issue;

   localparam int EW = 8;
   localparam int MW = 24;
   localparam int W  = 32;
   localparam int L  = 3;
   localparam int D  = 4;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_addsub_i;
   logic [W-1:0]  req_a_i;
   logic [W-1:0]  req_b_i;
   logic [TW-1:0] req_tag_i;
   logic          addsub_o;
   logic [W-1:0]  data_a_o;
   logic [W-1:0]  data_b_o;
   logic [W-1:0]  result_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [W-1:0]  rsp_result_o;
   logic [TW-1:0] rsp_tag_o;
   logic          busy_o;

   always #5 clk = ~clk;

   fp_addsub_issue #(
      .EXPONENT_WIDTH (EW),
      .MANTISSA_WIDTH (MW),
      .ADDSUB_LATENCY (L),
      .FIFO_DEPTH     (D),
      .TAG_WIDTH      (TW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addsub_i (req_addsub_i),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_tag_i    (req_tag_i),
      .addsub_o     (addsub_o),
      .data_a_o     (data_a_o),
      .data_b_o     (data_b_o),
      .result_i     (result_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_result_o (rsp_result_o),
      .rsp_tag_o    (rsp_tag_o),
      .busy_o       (busy_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Single precision <-> real, normal numbers only; bench operands are small
   // integers so every sum and difference is exact.
   function automatic real sp_to_real(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real_to_sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return 32'h0;
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fp_ref(input logic sub, input logic [31:0] a, input logic [31:0] b);
      real ra, rb;
      ra = sp_to_real(a);
      rb = sp_to_real(b);
      return real_to_sp(sub ? ra - rb : ra + rb);
   endfunction

   function automatic logic [31:0] rnd_fp();
      int v;
      v = int'($urandom_range(0, 2000)) - 1000;
      return real_to_sp(real'(v));
   endfunction

   // External adder: fixed L-cycle pipeline fed from the registered operands.
   logic [W-1:0] add_pipe [L];
   always @(posedge clk) begin
      add_pipe[0] <= fp_ref(addsub_o, data_a_o, data_b_o);
      for (int i = 1; i < L; i++) add_pipe[i] <= add_pipe[i-1];
   end
   assign result_i = add_pipe[L-1];

   // Transaction model: each accepted op is owed a response L+1 edges later,
   // in order, and keeps a credit until popped.
   logic [TW+W-1:0] exp_q[$];
   int              due_q[$];
   int              cyc = 0;
   int              out_cnt = 0;
   logic [W-1:0]    a_m, b_m;
   logic            op_m;
   bit              started = 0;

   always @(posedge clk) begin
      bit rdy_m, vis_m;
      rdy_m = (out_cnt < D);
      vis_m = (exp_q.size() > 0) && (due_q[0] <= cyc);
      cyc++;
      if (rst_i) begin
         exp_q.delete();
         due_q.delete();
         out_cnt = 0;
         a_m = '0; b_m = '0; op_m = 1'b0;
         started = 1;
      end else begin
         if (vis_m && rsp_ready_i) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            out_cnt--;
         end
         if (req_valid_i && rdy_m) begin
            exp_q.push_back({req_tag_i, fp_ref(req_addsub_i, req_a_i, req_b_i)});
            due_q.push_back(cyc + L + 1);
            out_cnt++;
            a_m = req_a_i; b_m = req_b_i; op_m = req_addsub_i;
         end
      end
   end

   always @(negedge clk) begin
      bit vis;
      if (started) begin
         vis = (exp_q.size() > 0) && (due_q[0] <= cyc);
         check("req_ready", 64'(req_ready_o), 64'(out_cnt < D));
         check("rsp_valid", 64'(rsp_valid_o), 64'(vis));
         check("busy", 64'(busy_o), 64'(out_cnt != 0));
         check("data_a", 64'(data_a_o), 64'(a_m));
         check("data_b", 64'(data_b_o), 64'(b_m));
         check("addsub", 64'(addsub_o), 64'(op_m));
         if (vis) begin
            check("rsp_result", 64'(rsp_result_o), 64'(exp_q[0][W-1:0]));
            check("rsp_tag", 64'(rsp_tag_o), 64'(exp_q[0][TW+W-1:W]));
         end
      end
   end

   task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic [TW-1:0] tag);
      req_valid_i  = 1'b1;
      req_a_i      = a;
      req_b_i      = b;
      req_addsub_i = op;
      req_tag_i    = tag;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic [TW-1:0] tag);
      logic rdy;
      int   n;
      n = 0;
      present(a, b, op, tag);
      do begin
         @(negedge clk);
         rdy = req_ready_o;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 100);
      check("send_accept", 64'(rdy), 64'd1);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(negedge clk);
         if (rsp_valid_o) break;
         lat++;
      end
      check("rsp_arrived", 64'(rsp_valid_o), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      while (busy_o !== 1'b0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_idle", 64'(busy_o), 64'd0);
   endtask

   initial begin
      int lat, acc, idx, stale;
      logic rdy;
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      req_addsub_i = 1'b0;
      req_a_i = '0;
      req_b_i = '0;
      req_tag_i = '0;
      rsp_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_ready", 64'(req_ready_o), 64'd1);
      check("reset_data_a", 64'(data_a_o), 64'd0);
      @(posedge clk); #1;

      // 1.0 + 2.0 = 3.0
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5);
      wait_rsp(lat);
      check("add_latency", 64'(lat), 64'(L + 1));
      check("add_result", 64'(rsp_result_o), 64'h4040_0000);
      check("add_tag", 64'(rsp_tag_o), 64'd5);
      @(posedge clk); #1;

      // 3.0 - 1.0 = 2.0
      send(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd2);
      wait_rsp(lat);
      check("sub_latency", 64'(lat), 64'(L + 1));
      check("sub_result", 64'(rsp_result_o), 64'h4000_0000);
      check("sub_tag", 64'(rsp_tag_o), 64'd2);
      @(posedge clk); #1;

      // Eight back-to-back requests, tags 0..7, always draining.
      for (int t = 0; t < 8; t++) send(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(t));
      drain();

      // Six offered with the response side stalled: only D fit.
      rsp_ready_i = 1'b0;
      acc = 0;
      idx = 0;
      present(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(idx));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rdy = req_ready_o;
         @(posedge clk);
         #1;
         if (rdy && req_valid_i) begin
            acc++;
            idx++;
            if (idx < 6) present(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(idx));
            else req_valid_i = 1'b0;
         end
      end
      check("credit_accepts", 64'(acc), 64'(D));
      @(negedge clk);
      check("credit_ready_low", 64'(req_ready_o), 64'd0);
      @(posedge clk); #1;
      rsp_ready_i = 1'b1;
      while (idx < 6) begin
         send(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(idx));
         idx++;
      end
      drain();

      // Fill the FIFO, then stream with single-cycle pops so pushes land on a
      // nearly full buffer while it is being popped.
      rsp_ready_i = 1'b0;
      for (int t = 0; t < D; t++) send(rnd_fp(), rnd_fp(), 1'b0, 4'(8 + t));
      repeat (L + 2) @(posedge clk);
      #1;
      for (int t = 0; t < 12; t++) begin
         present(rnd_fp(), rnd_fp(), 1'b1, 4'(t));
         rsp_ready_i = (t % 3 != 2);
         @(posedge clk);
         #1;
      end
      drain();

      // Reset with two ops in flight and one buffered.
      rsp_ready_i = 1'b0;
      for (int t = 0; t < 3; t++) send(rnd_fp(), rnd_fp(), 1'b0, 4'(t));
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_mid_busy", 64'(busy_o), 64'd0);
      check("rst_mid_ready", 64'(req_ready_o), 64'd1);
      rsp_ready_i = 1'b1;
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid_o !== 1'b0) stale++;
      end
      check("rst_no_stale", 64'(stale), 64'd0);
      @(posedge clk); #1;

      // Random traffic on both sides.
      for (int c = 0; c < 400; c++) begin
         req_valid_i  = ($urandom_range(0, 99) < 60);
         req_a_i      = rnd_fp();
         req_b_i      = rnd_fp();
         req_addsub_i = 1'($urandom_range(0, 1));
         req_tag_i    = 4'($urandom_range(0, 15));
         rsp_ready_i  = ($urandom_range(0, 99) < 55);
         @(posedge clk);
         #1;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
